// File: rtl/zbt_port_driver.sv
// ZBT SRAM port driver: turns one request per clock into pipelined ZBT pin timing, with read data back 3 edges after issue.
// Fixed latency with one op per cycle sustained; no stalls and no backpressure.
module zbt_port_driver #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_write,
    input  logic              i_mem_wr,
    output logic [DATA_W-1:0] o_mem_read,
    output logic              o_mem_read_valid,
    output logic [ADDR_W-1:0] o_mem_read_addr,
    output logic [ADDR_W-1:0] o_ram_addr,
    inout  wire  [DATA_W-1:0] io_ram_data,
    output logic              o_ram_we_b,
    output logic              o_ram_cen_b,
    output logic              o_ram_oe_b,
    output logic [3:0]        o_ram_bwe_b,
    output logic              o_ram_adv_ld
);

    typedef struct packed {
        logic              vld;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } stage_t;

    stage_t            r_s1;
    stage_t            r_s2;
    stage_t            r_s3;
    logic              r_we_b;
    logic              r_cen_b;
    logic              r_oe_b;
    logic [3:0]        r_bwe_b;
    logic [DATA_W-1:0] r_rd_dat;
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              w_dq_oe;
    logic              w_s3_rd;

    // S3 is the op whose data slot is on the bus this cycle: drive it if a write, capture it if a read.
    assign w_dq_oe = r_s3.vld & r_s3.wr;
    assign w_s3_rd = r_s3.vld & ~r_s3.wr;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1.vld  <= 1'b1;
            r_s1.wr   <= i_mem_wr;
            r_s1.addr <= i_mem_addr;
            r_s1.dat  <= i_mem_write;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_we_b  <= 1'b1;
            r_cen_b <= 1'b1;
            r_oe_b  <= 1'b1;
            r_bwe_b <= 4'hF;
        end else begin
            r_we_b  <= ~i_mem_wr;
            r_cen_b <= 1'b0;
            r_oe_b  <= 1'b0;
            r_bwe_b <= {4{~i_mem_wr}};
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_dat  <= '0;
            r_rd_addr <= '0;
        end else begin
            r_rd_vld <= w_s3_rd;
            if (w_s3_rd) begin
                r_rd_dat  <= io_ram_data;
                r_rd_addr <= r_s3.addr;
            end
        end
    end

    assign io_ram_data      = w_dq_oe ? r_s3.dat : 'z;
    assign o_ram_addr       = r_s1.addr;
    assign o_ram_we_b       = r_we_b;
    assign o_ram_cen_b      = r_cen_b;
    assign o_ram_oe_b       = r_oe_b;
    assign o_ram_bwe_b      = r_bwe_b;
    assign o_ram_adv_ld     = 1'b0;
    assign o_mem_read       = r_rd_dat;
    assign o_mem_read_valid = r_rd_vld;
    assign o_mem_read_addr  = r_rd_addr;

endmodule

// File: tb/tb_zbt_port_driver.sv
// Bench for zbt_port_driver: pin-level ZBT SRAM model plus an op-history reference model checked every cycle.
module tb_zbt_port_driver;

    localparam int            AW   = 19;
    localparam int            DW   = 36;
    localparam int            BASE = 'h100;
    localparam logic [DW-1:0] JUNK = 36'hFFFFFFFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_write = JUNK;
    logic          mem_wr = 1'b0;
    logic [DW-1:0] mem_read;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_addr;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_we_b;
    logic          ram_cen_b;
    logic          ram_oe_b;
    logic [3:0]    ram_bwe_b;
    logic          ram_adv_ld;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    zbt_port_driver #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clock          (clk),
        .i_reset_n        (rst_n),
        .i_mem_addr       (mem_addr),
        .i_mem_write      (mem_write),
        .i_mem_wr         (mem_wr),
        .o_mem_read       (mem_read),
        .o_mem_read_valid (mem_read_valid),
        .o_mem_read_addr  (mem_read_addr),
        .o_ram_addr       (ram_addr),
        .io_ram_data      (ram_data),
        .o_ram_we_b       (ram_we_b),
        .o_ram_cen_b      (ram_cen_b),
        .o_ram_oe_b       (ram_oe_b),
        .o_ram_bwe_b      (ram_bwe_b),
        .o_ram_adv_ld     (ram_adv_ld)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic bus_idle();
        return (ram_data === '0) || (ram_data === 'z);
    endfunction

    // ZBT SRAM device model: samples control at E1, drives read data for capture at E3, captures write data at E3.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic          sram_drv;
    logic [DW-1:0] sram_q;
    logic          p1_v, p1_wr, p2_v, p2_wr;
    logic [AW-1:0] p1_a, p2_a;

    assign ram_data = sram_drv ? sram_q : 'z;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v     <= 1'b0;
            p1_wr    <= 1'b0;
            p1_a     <= '0;
            p2_v     <= 1'b0;
            p2_wr    <= 1'b0;
            p2_a     <= '0;
            sram_drv <= 1'b0;
            sram_q   <= '0;
        end else begin
            if (p2_v && p2_wr) sram_mem[p2_a] <= ram_data;
            sram_drv <= p1_v && !p1_wr;
            sram_q   <= (p2_v && p2_wr && p2_a == p1_a) ? ram_data : sram_mem[p1_a];
            p2_v     <= p1_v;
            p2_wr    <= p1_wr;
            p2_a     <= p1_a;
            p1_v     <= !ram_cen_b;
            p1_wr    <= !ram_we_b;
            p1_a     <= ram_addr;
        end
    end

    // Reference model: ordered list of issued ops; a read sees the latest earlier write to its address.
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
    } op_t;

    op_t           hist[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    op_t           mdl_op;

    function automatic logic [DW-1:0] ref_lookup(input logic [AW-1:0] a);
        for (int i = hist.size() - 1; i >= 0; i--)
            if (hist[i].wr && hist[i].addr == a) return hist[i].wdat;
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[AW'(i)] = '0;
        sram_mem[19'h00040] = 36'hABCDE0123;
        ref_mem[19'h00040]  = 36'hABCDE0123;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hist.delete();
            end else begin
                // a write is durable once it has reached its capture edge
                if (hist.size() >= 3 && hist[hist.size()-3].wr)
                    ref_mem[hist[hist.size()-3].addr] = hist[hist.size()-3].wdat;
                mdl_op.wr   = mem_wr;
                mdl_op.addr = mem_addr;
                mdl_op.wdat = mem_write;
                mdl_op.rdat = mem_wr ? '0 : ref_lookup(mem_addr);
                hist.push_back(mdl_op);
            end
        end
    end

    // Per-cycle compare: after edge L the pins show op L, the bus carries op L-2, and the strobe reports op L-3.
    int            cmp_l;
    op_t           cmp_op;
    logic          cmp_v;
    logic [DW-1:0] exp_rd_dat = '0;
    logic [AW-1:0] exp_rd_addr = '0;

    initial forever begin
        @(negedge clk);
        if (!rst_n || hist.size() == 0) begin
            exp_rd_dat  = '0;
            exp_rd_addr = '0;
            chk("rst_cen_b",   64'(ram_cen_b), 64'(1));
            chk("rst_we_b",    64'(ram_we_b), 64'(1));
            chk("rst_oe_b",    64'(ram_oe_b), 64'(1));
            chk("rst_bwe_b",   64'(ram_bwe_b), 64'(4'hF));
            chk("rst_adv_ld",  64'(ram_adv_ld), 64'(0));
            chk("rst_addr",    64'(ram_addr), 64'(0));
            chk("rst_rd",      64'(mem_read), 64'(0));
            chk("rst_vld",     64'(mem_read_valid), 64'(0));
            chk("rst_rd_addr", 64'(mem_read_addr), 64'(0));
            chk("rst_bus_z",   64'(bus_idle()), 64'(1));
        end else begin
            cmp_l  = hist.size() - 1;
            cmp_op = hist[cmp_l];
            chk("pin_addr",   64'(ram_addr), 64'(cmp_op.addr));
            chk("pin_we_b",   64'(ram_we_b), 64'(!cmp_op.wr));
            chk("pin_bwe_b",  64'(ram_bwe_b), 64'(cmp_op.wr ? 4'h0 : 4'hF));
            chk("pin_cen_b",  64'(ram_cen_b), 64'(0));
            chk("pin_oe_b",   64'(ram_oe_b), 64'(0));
            chk("pin_adv_ld", 64'(ram_adv_ld), 64'(0));
            cmp_v = (cmp_l >= 3) && !hist[cmp_l-3].wr;
            if (cmp_v) begin
                exp_rd_dat  = hist[cmp_l-3].rdat;
                exp_rd_addr = hist[cmp_l-3].addr;
            end
            chk("rd_vld",  64'(mem_read_valid), 64'(cmp_v));
            chk("rd_dat",  64'(mem_read), 64'(exp_rd_dat));
            chk("rd_addr", 64'(mem_read_addr), 64'(exp_rd_addr));
            if (cmp_l >= 2)
                chk("bus_dat", 64'(ram_data),
                    64'(hist[cmp_l-2].wr ? hist[cmp_l-2].wdat : hist[cmp_l-2].rdat));
            else
                chk("bus_z_fill", 64'(bus_idle()), 64'(1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit %0d reached before summary", 100000);
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_wr    = wr;
        mem_addr  = a;
        mem_write = wr ? d : JUNK;
        @(posedge clk);
        #1;
    endtask

    logic          b2b_wr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] b2b_addr [8] = '{19'h5, 19'h5, 19'h6, 19'h6, 19'h5, 19'h3D0, 19'h3D1, 19'h3D2};
    logic [DW-1:0] got[$];
    int            cnt;
    logic [AW-1:0] a_i;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_read",  64'(mem_read), 64'(0));
        chk("reset_valid",     64'(mem_read_valid), 64'(0));
        chk("reset_we_b",      64'(ram_we_b), 64'(1));
        chk("reset_cen_b",     64'(ram_cen_b), 64'(1));
        chk("reset_bus_z",     64'(bus_idle()), 64'(1));
        rst_n = 1'b1;

        issue(1'b1, 19'h00012, 36'h123456789);
        chk("sw_ram_addr", 64'(ram_addr), 64'(19'h12));
        chk("sw_we_b",     64'(ram_we_b), 64'(0));
        chk("sw_bwe_b",    64'(ram_bwe_b), 64'(0));
        issue(1'b0, 19'h3F1, '0);
        chk("sw_bus_z_e1", 64'(bus_idle()), 64'(1));
        issue(1'b0, 19'h3F2, '0);
        chk("sw_bus_data", 64'(ram_data), 64'(36'h123456789));
        issue(1'b1, 19'h3F3, 36'h0F0F0F0F0);
        chk("sw_no_strobe", 64'(mem_read_valid), 64'(0));

        issue(1'b0, 19'h00040, '0);
        for (int k = 0; k < 3; k++) issue(1'b1, AW'(19'h3E0 + k), 36'h111111111);
        chk("sr_valid", 64'(mem_read_valid), 64'(1));
        chk("sr_data",  64'(mem_read), 64'(36'hABCDE0123));
        chk("sr_addr",  64'(mem_read_addr), 64'(19'h40));
        issue(1'b1, 19'h3E3, 36'h222222222);
        chk("sr_one_cycle", 64'(mem_read_valid), 64'(0));
        chk("sr_hold",      64'(mem_read), 64'(36'hABCDE0123));

        got.delete();
        for (int i = 0; i < 8; i++) begin
            issue(b2b_wr[i], b2b_addr[i], DW'(b2b_addr[i]));
            if (i >= 3 && mem_read_valid) got.push_back(mem_read);
        end
        chk("b2b_count", 64'(got.size()), 64'(3));
        if (got.size() == 3) begin
            chk("b2b_rd0", 64'(got[0]), 64'(36'h5));
            chk("b2b_rd1", 64'(got[1]), 64'(36'h6));
            chk("b2b_rd2", 64'(got[2]), 64'(36'h5));
        end

        cnt = 0;
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                a_i = AW'(BASE + i / 2);
                issue(!i[0], a_i, DW'(a_i));
            end else begin
                issue(1'b1, 19'h3C0, 36'h333333333);
            end
            if (i >= 3 && mem_read_valid) begin
                cnt++;
                chk("alt_rd", 64'(mem_read), 64'(BASE + (i - 3) / 2));
            end
        end
        chk("alt_strobes", 64'(cnt), 64'(50));

        for (int k = 0; k < 53; k++) begin
            if (k < 50) issue(1'b0, AW'(BASE + k), '0);
            else        issue(1'b1, 19'h3C1, 36'h444444444);
            if (k >= 3) begin
                chk("sweep_vld", 64'(mem_read_valid), 64'(1));
                chk("sweep_rd",  64'(mem_read), 64'(BASE + k - 3));
            end
        end

        issue(1'b1, 19'h00020, 36'hA5A5A5A5A);
        issue(1'b0, 19'h00021, '0);
        issue(1'b0, 19'h00022, '0);
        chk("mw_bus_driven", 64'(ram_data), 64'(36'hA5A5A5A5A));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mw_bus_z",  64'(bus_idle()), 64'(1));
        chk("mw_valid",  64'(mem_read_valid), 64'(0));
        chk("mw_cen_b",  64'(ram_cen_b), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        issue(1'b1, 19'h00077, 36'h777777777);
        chk("short_vld0", 64'(mem_read_valid), 64'(0));
        issue(1'b0, 19'h00077, '0);
        chk("short_vld1", 64'(mem_read_valid), 64'(0));
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("short_no_strobe", 64'(mem_read_valid), 64'(0));
        end
        chk("short_no_commit", 64'(sram_mem[19'h00077]), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zbt_port_driver.md
Name: zbt_port_driver

Overview:
- Memory-side responder for one of the two memory ports (mem0 or mem1) that memory_interface drives; one instance per port.
- Converts the single-cycle request (mem_addr, mem_write, mem_wr) into pipelined ZBT SRAM pin timing.
- Returns read data on mem_read with fixed latency, plus a valid strobe and the address tag.
- Owns the bidirectional data bus tristate and the reset-safe pin states.

Parameters:
- ADDR_W, 19, ZBT word address width (matches LOG_ADDR).
- DATA_W, 36, ZBT word width (matches LOG_MEM).

Ports:
- clock  in  1  system clock; the ZBT clock is phase-aligned to it outside this block.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  in  ADDR_W  request address, sampled every rising edge.
- mem_write  in  DATA_W  write data, sampled with the request.
- mem_wr  in  1  1 = write, 0 = read; sampled every edge.
- mem_read  out  DATA_W  read data return; holds its value between reads.
- mem_read_valid  out  1  one-cycle strobe when mem_read updates.
- mem_read_addr  out  ADDR_W  address of the read now on mem_read.
- ram_addr  out  ADDR_W  ZBT address pins.
- ram_data  inout  DATA_W  ZBT data bus.
- ram_we_b  out  1  ZBT write enable, active low.
- ram_cen_b  out  1  ZBT chip enable, active low.
- ram_oe_b  out  1  ZBT output enable, active low.
- ram_bwe_b  out  4  ZBT byte write enables, active low.
- ram_adv_ld  out  1  ZBT advance/load; always 0 (load mode, no bursts).

Behaviour:
- Request rule: every rising edge with reset_n high issues exactly one operation. There is no idle request; a read is issued whenever mem_wr=0.
- Reset (reset_n low, asynchronous, takes effect immediately):
  - ram_cen_b=1, ram_we_b=1, ram_oe_b=1, ram_bwe_b=4'hF, ram_adv_ld=0, ram_addr=0.
  - ram_data is released to Z.
  - mem_read=0, mem_read_valid=0, mem_read_addr=0.
  - All pipeline valid bits are cleared.
- First edge after reset release (E0): the request is captured.
  - ram_cen_b=0, ram_oe_b=0 from then on.
  - ram_addr<=mem_addr, ram_we_b<=~mem_wr, ram_bwe_b<=mem_wr ? 0 : F.
  - The SRAM samples these at E1.
- Pipeline: three register stages, S1 (pins), S2, S3. Each stage carries valid, wr, addr and data and shifts every edge.
- Write timing, for a request at E0:
  - Data reaches the output register at E2.
  - The output-enable register is set at E2, so ram_data is driven from just after E2 until just after E3.
  - The SRAM captures the data at E3.
  - The bus is driven only while the S3-stage op is a valid write; otherwise it is Z.
- Read timing, for a request at E0:
  - The SRAM drives data for capture at E3.
  - The block registers ram_data into mem_read at E3.
  - mem_read_valid=1 and mem_read_addr=the E0 address for the one cycle after E3.
  - Read latency is 3 cycles, edge to edge.
- Writes never set mem_read_valid and do not disturb mem_read.
- Back-to-back mixes need no dead cycle in either direction:
  - write→read: the bus is driven only in the write's data slot; the read's data slot is a different cycle.
  - read→write: the bus is released at the same edge the read is captured.
  - The tristate enable and the read capture never refer to the same op.
- Read-after-write to the same address on consecutive edges returns the new data. The SRAM guarantees this; the block must not reorder ops.
- Throughput: one op per cycle sustained, with no stalls and no backpressure.
- Fill after reset: mem_read_valid stays 0 for the first 3 edges. The first possible strobe follows E3 of the first request.
- Reset mid-operation: in-flight ops are dropped with no strobe, and the bus goes to Z immediately. In-flight writes may not complete.
- Width rules: no arithmetic is performed. Address and data pass through unchanged; ram_bwe_b is all-or-nothing.

Test Plan:
- Reset: hold reset_n=0 with ram_data externally driven to 36'h0 → mem_read=0, mem_read_valid=0, ram_we_b=1, ram_cen_b=1, ram_data Z from the block. Assert reset_n=0 mid-write → ram_data goes Z within the same cycle.
- Single write: addr=19'h00012, data=36'h123456789, mem_wr=1 at E0 → ram_addr=12 and ram_we_b=0 after E0; ram_data=36'h123456789 between E2 and E3; Z otherwise; mem_read_valid stays 0.
- Single read against a behavioural ZBT model preloaded with [19'h00040]=36'hABCDE0123 → mem_read=36'hABCDE0123, mem_read_addr=19'h40, mem_read_valid high exactly one cycle after E3.
- Back-to-back W(5,36'h5),R(5),W(6,36'h6),R(6),R(5) → reads return 36'h5, 36'h6, 36'h5 on consecutive valid strobes. There must be no bus contention: the model flags any cycle where both sides drive ram_data.
- 100-cycle alternating read/write (toggle mem_wr each edge, incrementing addr, data=addr) followed by a readback sweep → every read equals its address; exactly 50 strobes appear during the alternating phase once the pipeline is full.
- Reset released for 2 cycles, then reasserted → no mem_read_valid pulse and no SRAM write committed in the model.
